// File: rtl/ctrl_pkg.sv
// Shared constants and types for the ctrl_seq instruction sequencer:
// T-state one-hots, opcode class patterns, jump condition codes.
package ctrl_pkg;

  localparam logic [7:0] T0 = 8'h01;
  localparam logic [7:0] T1 = 8'h02;
  localparam logic [7:0] T2 = 8'h04;
  localparam logic [7:0] T3 = 8'h08;
  localparam logic [7:0] T4 = 8'h10;
  localparam logic [7:0] T5 = 8'h20;
  localparam logic [7:0] T6 = 8'h40;
  localparam logic [7:0] T7 = 8'h80;

  localparam logic [7:0] ALU_MASK  = 8'h80;
  localparam logic [7:0] ALU_PAT   = 8'h80;
  localparam logic [7:0] GRP_MASK  = 8'hFC;
  localparam logic [7:0] LOAD_PAT  = 8'h20;
  localparam logic [7:0] STORE_PAT = 8'h40;
  localparam logic [7:0] LDI_PAT   = 8'h24;
  localparam logic [7:0] JMP_PAT   = 8'h04;

  localparam logic [7:0] CTRL_RESET_OPCODE = 8'h00;

  typedef enum logic [1:0] {
    CC_ALWAYS = 2'b00,
    CC_Z      = 2'b01,
    CC_NZ     = 2'b10,
    CC_C      = 2'b11
  } cond_t;

  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic ldi;
    logic jmp;
    logic nop;
  } op_class_t;

  function automatic logic cond_met(input cond_t cc, input logic z, input logic c);
    logic met;
    case (cc)
      CC_ALWAYS: met = 1'b1;
      CC_Z:      met = z;
      CC_NZ:     met = ~z;
      CC_C:      met = c;
      default:   met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: one-hot instruction class plus the
// operation, source, destination and condition fields.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_t  cls,
  output logic [2:0] ooo,
  output logic [1:0] ss,
  output logic [1:0] dd,
  output cond_t      cc
);

  logic m_alu;
  logic m_load;
  logic m_store;
  logic m_ldi;
  logic m_jmp;

  assign m_alu   = (opcode & ALU_MASK) == ALU_PAT;
  assign m_load  = (opcode & GRP_MASK) == LOAD_PAT;
  assign m_store = (opcode & GRP_MASK) == STORE_PAT;
  assign m_ldi   = (opcode & GRP_MASK) == LDI_PAT;
  assign m_jmp   = (opcode & GRP_MASK) == JMP_PAT;

  // Anything unrecognised executes as a two-cycle NOP.
  assign cls = {m_alu, m_load, m_store, m_ldi, m_jmp,
                ~(m_alu | m_load | m_store | m_ldi | m_jmp)};

  assign ooo = opcode[6:4];
  assign ss  = opcode[3:2];
  assign dd  = opcode[1:0];
  assign cc  = cond_t'(opcode[1:0]);

endmodule

// File: rtl/ctrl_seq.sv
// One-hot T-state instruction sequencer with opcode prefetch and watchdog.
// Define CTRL_WAIT_EN to add the rdy input and memory wait states.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int         DATA_WIDTH   = 8,
  parameter int         NUM_T        = 8,
  parameter logic [7:0] RESET_OPCODE = CTRL_RESET_OPCODE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] iodb,
  input  logic                  flag_z,
  input  logic                  flag_c,
`ifdef CTRL_WAIT_EN
  input  logic                  rdy,
`endif
  output logic                  dl_db,
  output logic                  dl_abl,
  output logic                  dl_abh,
  output logic                  pci,
  output logic                  pcl_abl,
  output logic                  pch_abh,
  output logic                  pcl_db,
  output logic                  pch_db,
  output logic                  abl_pcl,
  output logic                  abh_pch,
  output logic [2:0]            op,
  output logic                  alue,
  output logic                  dbe,
  output logic                  sbe,
  output logic                  dbld,
  output logic                  ral_adl,
  output logic                  rah_adh,
  output logic                  rw,
  output logic [1:0]            dba,
  output logic [1:0]            sba,
  output logic                  sync,
  output logic [NUM_T-1:0]      tstate,
  output logic                  trap
);

  localparam logic [NUM_T-1:0] ST0 = NUM_T'(T0);
  localparam logic [NUM_T-1:0] ST1 = NUM_T'(T1);
  localparam logic [NUM_T-1:0] ST2 = NUM_T'(T2);
  localparam logic [NUM_T-1:0] ST3 = NUM_T'(T3);

  logic [NUM_T-1:0] state_q, state_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [7:0]       preop_q, preop_d;
  logic             trap_q, trap_d;

  op_class_t  cls;
  logic [2:0] ooo;
  logic [1:0] ss;
  logic [1:0] dd;
  cond_t      cc;

  logic rdy_i;
  logic state_ok;
  logic mem_cycle;
  logic stall;
  logic retire;
  logic direct;
  logic pci_raw;
  logic dbld_raw;

`ifdef CTRL_WAIT_EN
  assign rdy_i = rdy;
`else
  assign rdy_i = 1'b1;
`endif

  ctrl_decode u_decode (
    .opcode (opcode_q),
    .cls    (cls),
    .ooo    (ooo),
    .ss     (ss),
    .dd     (dd),
    .cc     (cc)
  );

  assign state_ok = (state_q != '0) && ((state_q & (state_q - NUM_T'(1))) == '0);
  assign sync     = (state_q == ST0);
  assign tstate   = state_q;
  assign trap     = trap_q;

  always_comb begin
    dl_db     = 1'b0;
    dl_abl    = 1'b0;
    dl_abh    = 1'b0;
    pcl_abl   = 1'b0;
    pch_abh   = 1'b0;
    pcl_db    = 1'b0;
    pch_db    = 1'b0;
    abl_pcl   = 1'b0;
    abh_pch   = 1'b0;
    op        = '0;
    alue      = 1'b0;
    dbe       = 1'b0;
    sbe       = 1'b0;
    ral_adl   = 1'b0;
    rah_adh   = 1'b0;
    rw        = 1'b0;
    dba       = '0;
    sba       = '0;
    pci_raw   = 1'b0;
    dbld_raw  = 1'b0;
    mem_cycle = 1'b0;
    retire    = 1'b0;
    direct    = 1'b0;

    if (state_ok) begin
      if (state_q == ST0) begin
        pcl_abl   = 1'b1;
        pch_abh   = 1'b1;
        pci_raw   = 1'b1;
        mem_cycle = 1'b1;
        if (cls.alu) begin
          op  = ooo;
          sba = ss;
          dba = dd;
          dbe = 1'b1;
          sbe = 1'b1;
        end
      end else if (state_q == ST1) begin
        if (cls.alu) begin
          alue     = 1'b1;
          dba      = dd;
          dbld_raw = 1'b1;
          retire   = 1'b1;
        end else if (cls.load) begin
          ral_adl   = 1'b1;
          rah_adh   = 1'b1;
          dba       = dd;
          dl_db     = 1'b1;
          dbld_raw  = 1'b1;
          mem_cycle = 1'b1;
          retire    = 1'b1;
        end else if (cls.store) begin
          ral_adl   = 1'b1;
          rah_adh   = 1'b1;
          dba       = dd;
          dbe       = 1'b1;
          rw        = 1'b1;
          mem_cycle = 1'b1;
          retire    = 1'b1;
        end else if (cls.ldi) begin
          // Immediate was prefetched into DL at T0; this fetch is the next opcode.
          dl_db     = 1'b1;
          dbld_raw  = 1'b1;
          dba       = dd;
          pcl_abl   = 1'b1;
          pch_abh   = 1'b1;
          pci_raw   = 1'b1;
          mem_cycle = 1'b1;
          retire    = 1'b1;
          direct    = 1'b1;
        end else if (cls.jmp) begin
          dl_abl    = 1'b1;
          pcl_abl   = 1'b1;
          pch_abh   = 1'b1;
          pci_raw   = 1'b1;
          mem_cycle = 1'b1;
        end else if (cls.nop) begin
          retire = 1'b1;
        end
      end else if (state_q == ST2 && cls.jmp) begin
        dl_abh = 1'b1;
        if (cond_met(cc, flag_z, flag_c)) begin
          abl_pcl = 1'b1;
          abh_pch = 1'b1;
        end
      end else if (state_q == ST3 && cls.jmp) begin
        pcl_abl   = 1'b1;
        pch_abh   = 1'b1;
        pci_raw   = 1'b1;
        mem_cycle = 1'b1;
        retire    = 1'b1;
        direct    = 1'b1;
      end
    end

    stall = mem_cycle & ~rdy_i;
    pci   = pci_raw & ~stall;
    dbld  = dbld_raw & ~stall;

    state_d  = state_q;
    opcode_d = opcode_q;
    preop_d  = preop_q;
    trap_d   = 1'b0;
    if (!state_ok) begin
      state_d  = ST0;
      opcode_d = RESET_OPCODE;
      trap_d   = 1'b1;
    end else if (!stall) begin
      if (state_q == ST0) begin
        preop_d = iodb[7:0];
      end
      if (retire) begin
        state_d  = ST0;
        opcode_d = direct ? iodb[7:0] : preop_q;
      end else begin
        state_d = state_q << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST0;
      opcode_q <= RESET_OPCODE;
      preop_q  <= 8'h00;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      preop_q  <= preop_d;
      trap_q   <= trap_d;
    end
  end

endmodule
